branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter N, default 12: global history width; PHT holds 2^N two-bit counters.
REQ-002 Parameter B, default 6: BTB index width; BTB holds 2^B entries; B SHALL be <= N.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 bp_ready  output  1  table initialisation complete; predictions valid.
REQ-006 f_req  input  1  fetch consumes the prediction this cycle.
REQ-007 f_pc  input  32  fetch PC.
REQ-008 pred_taken  output  1  predicted direction for f_pc.
REQ-009 pred_pc  output  32  predicted next PC.
REQ-010 pred_history  output  N  GHR value used for this prediction; travels down the pipe.
REQ-011 upd_valid  input  1  resolved control-flow instruction from execute.
REQ-012 upd_pc  input  32  PC of resolved instruction.
REQ-013 upd_is_branch  input  1  conditional branch.
REQ-014 upd_is_jump  input  1  JAL/JALR.
REQ-015 upd_taken  input  1  actual direction.
REQ-016 upd_target  input  32  actual target.
REQ-017 upd_history  input  N  pred_history carried with that instruction.
REQ-018 upd_mispredict  input  1  execute redirected fetch.

Function
REQ-019 States SHALL be INIT and READY; bp_ready = (state==READY).
REQ-020 In INIT, counter cnt (N bits) SHALL write PHT[cnt]=2'b01 and clear BTB valid at cnt[B-1:0] each cycle, increment, and move to READY after writing cnt=2^N-1.
REQ-021 In INIT, pred_taken SHALL be 0, pred_pc = f_pc+4, and GHR and all upd_* writes SHALL be ignored.
REQ-022 Prediction SHALL be combinational (zero latency): idx = f_pc[N+1:2] XOR GHR; BTB hit = valid AND tag == f_pc[31:B+2] at entry f_pc[B+1:2].
REQ-023 pred_taken = hit AND (entry kind==jump OR PHT[idx][1]); pred_pc = pred_taken ? BTB target : f_pc+4 (mod 2^32).
REQ-024 pred_history SHALL equal the current GHR (value before any speculative shift).
REQ-025 Speculative GHR: on f_req AND READY AND hit AND kind==branch, GHR <= {GHR[N-2:0], pred_taken}.
REQ-026 Recovery: on upd_valid AND upd_mispredict, GHR <= upd_is_branch ? {upd_history[N-2:0], upd_taken} : upd_history; this SHALL take priority over REQ-025 in the same cycle.
REQ-027 PHT update: on upd_valid AND upd_is_branch, counter at upd_pc[N+1:2] XOR upd_history SHALL increment if taken, decrement otherwise, saturating at 2'b11 and 2'b00.
REQ-028 BTB update: on upd_valid AND (upd_is_jump OR (upd_is_branch AND upd_taken)), entry upd_pc[B+1:2] <= {valid=1, tag, upd_target, kind}; a not-taken branch SHALL NOT allocate.
REQ-029 Same-cycle read and write of one PHT/BTB entry: prediction SHALL use the old value; the new value is visible the next cycle.
REQ-030 upd_valid with both upd_is_branch and upd_is_jump low SHALL change no state.

Reset
REQ-031 rst high SHALL set state=INIT, cnt=0, GHR=0, bp_ready=0 at the next edge, including mid-sweep or while READY.
REQ-032 After rst deasserts, bp_ready SHALL rise exactly 2^N cycles later (4096 for N=12).
REQ-033 Outputs during reset/INIT: pred_taken=0, pred_pc=f_pc+4, pred_history=0.

Verification
REQ-034 Reset, then count cycles -> bp_ready=0 for 4096 cycles, 1 on cycle 4096; any f_pc=0x100 gives pred_pc=0x104.
REQ-035 Two taken updates for branch pc=0x80, target 0x40, history 0 -> f_pc=0x80, GHR=0 predicts taken, pred_pc=0x40; f_req shifts GHR to 0x001.
REQ-036 Four not-taken updates then one taken at the same index -> counter saturates at 00 then reads 01; pred_taken=0.
REQ-037 f_req hit and upd_mispredict (upd_history=0x0A5, taken=1, is_branch) in one cycle -> GHR next cycle = 0x14B, speculative shift discarded.
REQ-038 JAL update pc=0x200, target 0x400 -> f_pc=0x200 predicts taken regardless of PHT; not-taken branch at 0x300 -> no BTB entry, pred_pc=0x304.
REQ-039 rst pulsed while READY with trained tables -> bp_ready=0, full 4096-cycle sweep, prior training erased (0x80 predicts 0x84).

Source files
------------

// File: rtl/branch_predictor.sv
// Gshare direction predictor (2-bit PHT indexed by PC xor GHR) with a direct-mapped BTB.
// Tables are swept to a known state after reset before predictions are trusted.
//
// state | meaning
// INIT  | sweeping PHT to weakly-not-taken and BTB to invalid; predictions forced to fall-through
// READY | tables valid; predicting and accepting updates
module branch_predictor #(
  parameter int N = 12,
  parameter int B = 6
) (
  input  logic          clk,
  input  logic          rst,
  output logic          bp_ready,
  input  logic          f_req,
  input  logic [31:0]   f_pc,
  output logic          pred_taken,
  output logic [31:0]   pred_pc,
  output logic [N-1:0]  pred_history,
  input  logic          upd_valid,
  input  logic [31:0]   upd_pc,
  input  logic          upd_is_branch,
  input  logic          upd_is_jump,
  input  logic          upd_taken,
  input  logic [31:0]   upd_target,
  input  logic [N-1:0]  upd_history,
  input  logic          upd_mispredict
);

  localparam int TW = 30 - B;

  typedef enum logic {INIT, READY} state_t;

  state_t         state;
  logic [N-1:0]   cnt;
  logic [N-1:0]   ghr;

  logic [1:0]     pht        [2**N];
  logic           btb_valid  [2**B];
  logic [TW-1:0]  btb_tag    [2**B];
  logic [31:0]    btb_target [2**B];
  logic           btb_jump   [2**B];

  logic [N-1:0]   f_idx;
  logic [B-1:0]   f_slot;
  logic           hit;
  logic           ready;

  logic [N-1:0]   u_idx;
  logic [B-1:0]   u_slot;
  logic           upd_ok;
  logic           pht_we;
  logic           btb_we;
  logic           recover;
  logic           spec_shift;

  logic           unused_upd_pc;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) sat_step = (c == 2'b11) ? c : c + 2'b01;
    else    sat_step = (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign ready  = (state == READY);
  assign f_idx  = f_pc[N+1:2] ^ ghr;
  assign f_slot = f_pc[B+1:2];
  assign hit    = btb_valid[f_slot] && (btb_tag[f_slot] == f_pc[31:B+2]);

  assign bp_ready     = ready;
  assign pred_taken   = ready && hit && (btb_jump[f_slot] || pht[f_idx][1]);
  assign pred_pc      = pred_taken ? btb_target[f_slot] : f_pc + 32'd4;
  assign pred_history = ghr;

  assign u_idx   = upd_pc[N+1:2] ^ upd_history;
  assign u_slot  = upd_pc[B+1:2];
  assign upd_ok  = ready && upd_valid;
  assign pht_we  = upd_ok && upd_is_branch;
  assign btb_we  = upd_ok && (upd_is_jump || (upd_is_branch && upd_taken));
  // An update that is neither branch nor jump must not disturb the history either.
  assign recover = upd_ok && upd_mispredict && (upd_is_branch || upd_is_jump);
  assign spec_shift = ready && f_req && hit && !btb_jump[f_slot];

  assign unused_upd_pc = ^upd_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      ghr   <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + N'(1);
          if (cnt == '1) state <= READY;
        end
        READY: begin
          if (recover)
            ghr <= upd_is_branch ? {upd_history[N-2:0], upd_taken} : upd_history;
          else if (spec_shift)
            ghr <= {ghr[N-2:0], pred_taken};
        end
        default: state <= INIT;
      endcase
    end
  end

  // Table storage has no reset of its own; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        pht[cnt]                <= 2'b01;
        btb_valid[cnt[B-1:0]]   <= 1'b0;
      end else begin
        if (pht_we) pht[u_idx] <= sat_step(pht[u_idx], upd_taken);
        if (btb_we) begin
          btb_valid[u_slot]  <= 1'b1;
          btb_tag[u_slot]    <= upd_pc[31:B+2];
          btb_target[u_slot] <= upd_target;
          btb_jump[u_slot]   <= upd_is_jump;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: init sweep length, training, history
// speculation/recovery, BTB allocation rules and reset erasure.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        bp_ready;
  logic        f_req;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [11:0] pred_history;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [11:0] upd_history;
  logic        upd_mispredict;

  int checks = 0;
  int failures = 0;
  int n;

  branch_predictor #(.N(12), .B(6)) dut (
    .clk(clk), .rst(rst), .bp_ready(bp_ready),
    .f_req(f_req), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_history(pred_history),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_history(upd_history), .upd_mispredict(upd_mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    f_pc = pc;
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tgt,
                           input logic [11:0] hist, input logic mp);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
    upd_taken = tk; upd_target = tgt; upd_history = hist; upd_mispredict = mp;
  endtask

  task automatic clear_upd();
    upd_valid = 1'b0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic br, input logic jmp,
                        input logic tk, input logic [31:0] tgt,
                        input logic [11:0] hist, input logic mp);
    drive_upd(pc, br, jmp, tk, tgt, hist, mp);
    cycle();
    clear_upd();
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!bp_ready && cycles < 5000) begin
      cycle();
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; f_pc = 32'h100;
    upd_pc = '0; upd_target = '0; upd_history = '0;
    clear_upd();
    cycle(); cycle();
    check("rst_ready", bp_ready, 0);
    check("rst_taken", pred_taken, 0);
    check("rst_pc", pred_pc, 32'h104);
    check("rst_hist", pred_history, 0);

    // Sweep length; a jump update late in INIT must be ignored.
    rst = 1'b0;
    n = 0;
    while (!bp_ready && n < 5000) begin
      if (n == 4000) drive_upd(32'h700, 1'b0, 1'b1, 1'b1, 32'h900, 12'h0, 1'b0);
      else clear_upd();
      cycle();
      n++;
    end
    clear_upd();
    check("init_cycles", n, 4096);
    look(32'h100);
    check("ready_pc_100", pred_pc, 32'h104);
    look(32'h700);
    check("init_upd_ignored", pred_pc, 32'h704);

    // Train 0x80 taken (third update probes saturation at 11).
    repeat (3) update(32'h80, 1'b1, 1'b0, 1'b1, 32'h40, 12'h0, 1'b0);
    look(32'h80);
    check("br80_taken", pred_taken, 1);
    check("br80_pc", pred_pc, 32'h40);
    check("br80_hist", pred_history, 0);
    f_req = 1'b1; cycle(); f_req = 1'b0;
    check("spec_shift", pred_history, 12'h001);
    #1;
    check("ghr1_idx_pc", pred_pc, 32'h84);

    // Mispredicted not-taken branch at 0x300: restores GHR to 0, no BTB alloc.
    update(32'h300, 1'b1, 1'b0, 1'b0, 32'h999, 12'h0, 1'b1);
    check("recover_nt", pred_history, 0);
    look(32'h300);
    check("nt_no_alloc_taken", pred_taken, 0);
    check("nt_no_alloc_pc", pred_pc, 32'h304);

    // JAL at 0x200: taken regardless of weak-not-taken PHT; no GHR shift.
    update(32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 12'h0, 1'b0);
    look(32'h200);
    check("jal_taken", pred_taken, 1);
    check("jal_pc", pred_pc, 32'h400);
    f_req = 1'b1; cycle(); f_req = 1'b0;
    check("jal_no_shift", pred_history, 0);

    // Neither branch nor jump: no state change even with mispredict.
    update(32'h80, 1'b0, 1'b0, 1'b1, 32'h123, 12'hFFF, 1'b1);
    check("noop_hist", pred_history, 0);
    look(32'h80);
    check("noop_btb", pred_pc, 32'h40);

    // Same-cycle speculative shift and recovery: recovery wins.
    look(32'h80);
    f_req = 1'b1;
    update(32'h2000, 1'b1, 1'b0, 1'b1, 32'h3000, 12'h0A5, 1'b1);
    f_req = 1'b0;
    check("recover_prio", pred_history, 12'h14B);
    update(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 12'h0, 1'b1);
    check("recover_zero", pred_history, 0);

    // Lower saturation: 4x not-taken then taken leaves counter at 01.
    repeat (4) update(32'h1C4, 1'b1, 1'b0, 1'b0, 32'h0, 12'h0, 1'b0);
    update(32'h1C4, 1'b1, 1'b0, 1'b1, 32'h40, 12'h0, 1'b0);
    look(32'h1C4);
    check("sat_low_taken", pred_taken, 0);
    check("sat_low_pc", pred_pc, 32'h1C8);

    // Same-cycle write of a BTB entry: old value seen now, new next cycle.
    look(32'h500);
    drive_upd(32'h500, 1'b0, 1'b1, 1'b1, 32'h600, 12'h0, 1'b0);
    #1;
    check("rw_old", pred_pc, 32'h504);
    cycle();
    clear_upd();
    check("rw_new", pred_pc, 32'h600);
    look(32'h600);
    check("tag_miss", pred_pc, 32'h604);

    // Reset while READY, plus a second reset mid-sweep.
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst2_ready", bp_ready, 0);
    repeat (100) cycle();
    check("mid_sweep_ready", bp_ready, 0);
    rst = 1'b1; cycle(); rst = 1'b0;
    wait_ready(n);
    check("init_cycles_2", n, 4096);
    look(32'h80);
    check("erased_80_taken", pred_taken, 0);
    check("erased_80_pc", pred_pc, 32'h84);
    look(32'h200);
    check("erased_200_pc", pred_pc, 32'h204);
    check("erased_hist", pred_history, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
